// File: rtl/iop_generator.sv
// ---------------------------------------------------------------------------
// iop_generator
//
// Generates the three IOP pulses (IOP1, IOP2, IOP4) of one IOT instruction.
// A sequence always walks the three slots P1/G1, P2/G2, P4/G4 in order and
// then strobes DONE. Every slot keeps its full timing even when its enable
// bit is clear, so the sequence length never changes. The device skip
// request is latched while any pulse is on the bus. The result is presented
// on skip_out during the DONE cycle.
//
// Parameters
//   PULSE_CYCLES  IOP pulse width in clocks (1..255)
//   GAP_CYCLES    dead time after each pulse slot in clocks (1..255)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   iot_start  request one IOT sequence (sampled only in IDLE)
//   mb_iop     MB bits 9..11: [0]=IOP1, [1]=IOP2, [2]=IOP4 enable
//   skip_in    device skip request from the I/O bus
//   io_stall   (IOP_STALL_EN only) holds the gap counter while in a Gn state
//   iop1/2/4   registered IOP pulses to the bus drivers
//   busy       high while a sequence is in progress (P1..DONE)
//   done       one-clock end-of-sequence strobe
//   skip_out   latched skip result, valid only during done
//
// Configuration macro
//   IOP_STALL_EN  when defined, adds the io_stall port and lets it stretch
//                 the gap slots; when undefined, gap timing is fixed.
// ---------------------------------------------------------------------------
module iop_generator #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iot_start,
  input  logic [2:0] mb_iop,
  input  logic       skip_in,
`ifdef IOP_STALL_EN
  input  logic       io_stall,
`endif
  output logic       iop1,
  output logic       iop2,
  output logic       iop4,
  output logic       busy,
  output logic       done,
  output logic       skip_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    G1   = 3'd2,
    P2   = 3'd3,
    G2   = 3'd4,
    P4   = 3'd5,
    G4   = 3'd6,
    DONE = 3'd7
  } state_t;

  // The counter holds "clocks remaining minus one" in the current state, so a
  // state is left when the counter reads zero. That makes the reload value
  // width-1 and keeps the counter from ever having to go below zero.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] en;
  logic       skip_lat;

  logic       cnt_zero;
  logic       skip_hit;
  logic       gap_hold;

  assign cnt_zero = (cnt == 8'd0);

  // A skip request only counts while a pulse is actually being driven, so it
  // is qualified with the registered pulse outputs of the current cycle.
  assign skip_hit = skip_in & (iop1 | iop2 | iop4);

`ifdef IOP_STALL_EN
  assign gap_hold = io_stall;
`else
  assign gap_hold = 1'b0;
`endif

  // Single FSM register block. All outputs are registered and are written
  // together with the state they belong to, so each pulse lines up exactly
  // with its Pn state and done/skip_out line up with DONE. done and skip_out
  // default low every clock and are raised only on the transition into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      en       <= 3'b000;
      skip_lat <= 1'b0;
      iop1     <= 1'b0;
      iop2     <= 1'b0;
      iop4     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      skip_out <= 1'b0;
    end else begin
      done     <= 1'b0;
      skip_out <= 1'b0;

      // The latch is only ever set during a sequence. It is cleared on the
      // start edge, where no pulse can be active.
      if (skip_hit) begin
        skip_lat <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (iot_start) begin
            state    <= P1;
            cnt      <= PULSE_LOAD;
            en       <= mb_iop;
            skip_lat <= 1'b0;
            iop1     <= mb_iop[0];
            busy     <= 1'b1;
          end
        end

        P1: begin
          if (cnt_zero) begin
            state <= G1;
            cnt   <= GAP_LOAD;
            iop1  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        G1: begin
          if (!gap_hold) begin
            if (cnt_zero) begin
              state <= P2;
              cnt   <= PULSE_LOAD;
              iop2  <= en[1];
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        P2: begin
          if (cnt_zero) begin
            state <= G2;
            cnt   <= GAP_LOAD;
            iop2  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        G2: begin
          if (!gap_hold) begin
            if (cnt_zero) begin
              state <= P4;
              cnt   <= PULSE_LOAD;
              iop4  <= en[2];
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        P4: begin
          if (cnt_zero) begin
            state <= G4;
            cnt   <= GAP_LOAD;
            iop4  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        // No pulse is active in G4, so the latch is already final here and
        // can be presented directly on the DONE cycle.
        G4: begin
          if (!gap_hold) begin
            if (cnt_zero) begin
              state    <= DONE;
              cnt      <= 8'd0;
              done     <= 1'b1;
              skip_out <= skip_lat;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        // DONE always lasts one clock. A start request seen here is dropped;
        // a new sequence has to be requested from IDLE.
        DONE: begin
          state <= IDLE;
          cnt   <= 8'd0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
          iop1  <= 1'b0;
          iop2  <= 1'b0;
          iop4  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iop_generator.sv
// ---------------------------------------------------------------------------
// tb_iop_generator
//
// Self-checking bench for iop_generator with default parameters.
// Input cycle c is the clock period that ends at a sampling edge. Outputs are
// compared 1 time unit after that edge, which is cycle c+1.
// The reference model describes a sequence by its position inside the fixed
// slot timeline. It does not model the FSM states.
// ---------------------------------------------------------------------------
module tb_iop_generator;

  localparam int P       = 4;
  localparam int G       = 2;
  localparam int SLOT    = P + G;
  localparam int SEQ_LEN = 3 * SLOT + 1;

`ifdef IOP_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       iot_start;
  logic [2:0] mb_iop;
  logic       skip_in;
  logic       stall_req;
  logic       iop1, iop2, iop4, busy, done, skip_out;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  bit       m_active;
  int       m_pos;
  bit [2:0] m_en;
  bit       m_skl;

  always #5 clk = ~clk;

`ifdef IOP_STALL_EN
  logic io_stall;
  assign io_stall = stall_req;
`endif

  iop_generator #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .iot_start (iot_start),
    .mb_iop    (mb_iop),
    .skip_in   (skip_in),
`ifdef IOP_STALL_EN
    .io_stall  (io_stall),
`endif
    .iop1      (iop1),
    .iop2      (iop2),
    .iop4      (iop4),
    .busy      (busy),
    .done      (done),
    .skip_out  (skip_out)
  );

  typedef struct {
    logic       start;
    logic [2:0] mb;
    logic       skip;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic bit in_pulse(int pos, int slot);
    return (pos >= slot * SLOT + 1) && (pos <= slot * SLOT + P);
  endfunction

  function automatic bit in_gap(int pos);
    bit g = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if ((pos >= s * SLOT + P + 1) && (pos <= (s + 1) * SLOT)) g = 1'b1;
    end
    return g;
  endfunction

  // {iop1, iop2, iop4, busy, done, skip_out}
  function automatic logic [5:0] model_outs();
    logic [5:0] o;
    o = 6'b000000;
    if (m_active) begin
      o[5] = m_en[0] && in_pulse(m_pos, 0);
      o[4] = m_en[1] && in_pulse(m_pos, 1);
      o[3] = m_en[2] && in_pulse(m_pos, 2);
      o[2] = 1'b1;
      o[1] = (m_pos == SEQ_LEN);
      o[0] = (m_pos == SEQ_LEN) && m_skl;
    end
    return o;
  endfunction

  task automatic applyStimulus(input logic start, input logic [2:0] mb,
                               input logic skip, input logic stall,
                               input logic r);
    logic [5:0] cur;
    iot_start = start;
    mb_iop    = mb;
    skip_in   = skip;
    stall_req = stall;
    rst       = r;
    cur = model_outs();
    @(posedge clk);
    #1;
    if (r) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_en     = 3'b000;
      m_skl    = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_pos    = 1;
        m_en     = mb;
        m_skl    = 1'b0;
      end
    end else begin
      if (skip && (cur[5] || cur[4] || cur[3])) m_skl = 1'b1;
      if (m_pos == SEQ_LEN) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else if (!(in_gap(m_pos) && stall && STALL_ON)) begin
        m_pos = m_pos + 1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int cyc,
                             input logic [5:0] exp);
    logic [5:0] act;
    act = {iop1, iop2, iop4, busy, done, skip_out};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: {iop1,iop2,iop4,busy,done,skip_out} got %b expected %b",
               name, cyc, act, exp);
    end
  endtask

  // one cycle of stimulus followed by a comparison against the model
  task automatic stepModel(input string name, input int cyc, input logic start,
                           input logic [2:0] mb, input logic skip,
                           input logic stall, input logic r);
    applyStimulus(start, mb, skip, stall, r);
    checkOutput(name, cyc, model_outs());
  endtask

  initial begin
    logic [2:0] sc_mb [4];
    int         sc_skip [4];
    bit         sc_sexp [4];
    vec_t       v;
    int         n;

    // Scenarios with expected values taken from the published waveforms:
    // full enable, IOP2 with skip during its pulse, IOP2 with skip in the
    // gap only, and no enables with skip held high throughout.
    sc_mb[0] = 3'b111; sc_skip[0] = -1; sc_sexp[0] = 1'b0;
    sc_mb[1] = 3'b010; sc_skip[1] = 8;  sc_sexp[1] = 1'b1;
    sc_mb[2] = 3'b010; sc_skip[2] = 5;  sc_sexp[2] = 1'b0;
    sc_mb[3] = 3'b000; sc_skip[3] = -2; sc_sexp[3] = 1'b0;
    for (int sc = 0; sc < 4; sc++) begin
      for (int c = 0; c <= 20; c++) begin
        n = c + 1;
        v.start  = (c == 0);
        v.mb     = sc_mb[sc];
        v.skip   = (sc_skip[sc] == -2) || (c == sc_skip[sc]);
        v.exp[5] = sc_mb[sc][0] && (n >= 1)  && (n <= 4);
        v.exp[4] = sc_mb[sc][1] && (n >= 7)  && (n <= 10);
        v.exp[3] = sc_mb[sc][2] && (n >= 13) && (n <= 16);
        v.exp[2] = (n >= 1) && (n <= 19);
        v.exp[1] = (n == 19);
        v.exp[0] = (n == 19) && sc_sexp[sc];
        tbl.push_back(v);
      end
    end

    iot_start = 1'b0; mb_iop = 3'b000; skip_in = 1'b0; stall_req = 1'b0; rst = 1'b1;
    m_active = 1'b0; m_pos = 0; m_en = 3'b000; m_skl = 1'b0;

    // reset, including reset winning over a simultaneous start
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("reset", 0, 6'b000000);
    applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_over_start", 1, 6'b000000);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_after_reset", 2, 6'b000000);

    $display("[TB] table vectors");
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].start, tbl[i].mb, tbl[i].skip, 1'b0, 1'b0);
      checkOutput("table", (i % 21) + 1, tbl[i].exp);
    end

    $display("[TB] restart attempts while busy and in DONE");
    for (int c = 0; c <= 23; c++) begin
      stepModel("restart", c + 1, (c == 0) || (c == 10) || (c == 19) || (c == 20),
                3'b001, 1'b0, 1'b0, 1'b0);
      if (c == 19) checkOutput("idle_at_20", 20, 6'b000000);
      if (c == 20) checkOutput("iop1_at_21", 21, 6'b100100);
    end
    for (int c = 0; c < 20; c++) stepModel("drain", c, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset during iop1");
    for (int c = 0; c <= 24; c++) begin
      stepModel("rst_mid", c + 1, (c == 0), 3'b111, 1'b0, 1'b0, (c == 3));
      if (c == 3) checkOutput("rst_drops_iop1", 4, 6'b000000);
    end
    for (int c = 0; c <= 20; c++) begin
      stepModel("after_rst", c + 1, (c == 0), 3'b111, 1'b0, 1'b0, 1'b0);
      if (c == 18) checkOutput("after_rst_done", 19, 6'b000110);
    end

`ifdef IOP_STALL_EN
    $display("[TB] gap stall");
    for (int c = 0; c <= 23; c++) begin
      stepModel("stall_gap", c + 1, (c == 0), 3'b111, 1'b0, (c >= 5) && (c <= 7), 1'b0);
      if (c == 9)  checkOutput("stall_iop2_start", 10, 6'b010100);
      if (c == 21) checkOutput("stall_done", 22, 6'b000110);
    end
    for (int c = 0; c <= 20; c++) begin
      stepModel("stall_pulse", c + 1, (c == 0), 3'b111, 1'b0, (c >= 1) && (c <= 3), 1'b0);
      if (c == 18) checkOutput("stall_pulse_done", 19, 6'b000110);
    end
`endif

    $display("[TB] randomized stimulus");
    for (int c = 0; c < 4000; c++) begin
      stepModel("random", c,
                $urandom_range(0, 3) == 0,
                3'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iop_generator.md
IOP_GENERATOR -- requirements
Module: iop_generator

Interface
REQ-001 Parameter PULSE_CYCLES, default 4, SHALL set the IOP pulse width in clocks (legal 1..255).
REQ-002 Parameter GAP_CYCLES, default 2, SHALL set the dead time after each IOP slot in clocks (legal 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 iot_start  input  1  SHALL request one IOT sequence; sampled only in IDLE.
REQ-006 mb_iop  input  3  SHALL carry MB bits 9..11; [0]=IOP1 enable, [1]=IOP2 enable, [2]=IOP4 enable.
REQ-007 skip_in  input  1  SHALL be the device skip request from the I/O bus.
REQ-008 iop1, iop2, iop4  output  1 each  SHALL be the IOP pulses, routed to the bus driver inputs.
REQ-009 busy  output  1  SHALL be high while a sequence is in progress.
REQ-010 done  output  1  SHALL be a one-clock end-of-sequence strobe.
REQ-011 skip_out  output  1  SHALL be the latched skip result, valid on the done cycle.
REQ-012 io_stall  input  1  SHALL exist only when IOP_STALL_EN is defined.

Function
REQ-013 FSM states: IDLE, P1, G1, P2, G2, P4, G4, DONE.
REQ-014 IDLE with iot_start=1 at edge k: latch mb_iop, clear skip latch, enter P1 at k+1.
REQ-015 Each Pn state SHALL last exactly PULSE_CYCLES clocks; each Gn exactly GAP_CYCLES clocks (absent stall).
REQ-016 Transition order: P1->G1->P2->G2->P4->G4->DONE->IDLE; DONE lasts one clock.
REQ-017 iopN SHALL be high exactly during state PN when the latched enable bit is 1, else low; all outputs registered.
REQ-018 A disabled slot SHALL still occupy its full PULSE_CYCLES; sequence length is fixed.
REQ-019 Busy span SHALL be 3*(PULSE_CYCLES+GAP_CYCLES)+1 clocks, covering P1 through DONE inclusive.
REQ-020 busy SHALL be low in IDLE and high in every other state.
REQ-021 done SHALL be high only in DONE.
REQ-022 skip latch SHALL be set by skip_in=1 in any cycle when any iopN output is high; it never clears mid-sequence.
REQ-023 skip_out SHALL equal the skip latch during DONE and be 0 in all other states.
REQ-024 iot_start while busy=1 SHALL be ignored and not queued.
REQ-025 iot_start high in the DONE cycle SHALL be ignored; a new sequence may start from IDLE on the next clock.
REQ-026 mb_iop changes after the start edge SHALL not affect the running sequence.
REQ-027 mb_iop=000 SHALL run the full timed sequence with no pulses; skip_out=0.
REQ-028 The slot counter SHALL be 8 bits, reload on every state entry, and never wrap.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE and clear the counter, the enable latch, and the skip latch.
REQ-030 After reset: iop1=iop2=iop4=busy=done=skip_out=0 from the next clock.
REQ-031 Reset mid-pulse SHALL drop the active iopN on the next clock with no done strobe.
REQ-032 rst SHALL take priority over iot_start in the same cycle.

Configuration
REQ-033 Macro IOP_STALL_EN defined: io_stall=1 in any Gn state SHALL hold the counter, extending the gap; stall in Pn, IDLE, or DONE is ignored.
REQ-034 IOP_STALL_EN undefined: port io_stall SHALL be absent and gap timing SHALL be fixed.

Verification
REQ-035 Defaults, mb_iop=111, start pulse at cycle 0: iop1 high cycles 1-4, iop2 high 7-10, iop4 high 13-16, done at 19, busy 1-19.
REQ-036 mb_iop=010, skip_in=1 at cycle 8: only iop2 pulses, skip_out=1 at cycle 19; skip_in=1 only at cycle 5 gives skip_out=0.
REQ-037 Second iot_start at cycle 10 during a sequence: no effect; idle resumes at 20; start at 20 gives iop1 high at 21.
REQ-038 rst at cycle 3 during iop1: iop1 low from 4, busy=0, no done; later start runs a normal sequence.
REQ-039 IOP_STALL_EN, io_stall high cycles 5-7 in G1: iop2 delayed 3 clocks to 10-13, done at 22; same stall during P1 has no effect.
